// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state encoding and event record for the PS/2 key sequencer.
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        GAP
    } ps2_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       make;
        logic       ext;
        logic       is_repeat;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small key-event FIFO; head is read combinationally from the registered array.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned QAW    = $clog2(QDEPTH)
) (
    input  logic     i_clk,
    input  logic     i_clrn,
    input  logic     i_push,
    input  ps2_evt_t i_push_data,
    input  logic     i_pop,
    output ps2_evt_t o_head,
    output logic     o_valid,
    output logic     o_full
);

    localparam logic [QAW:0] LP_FULL = (QAW+1)'(QDEPTH);

    ps2_evt_t       r_mem [QDEPTH];
    logic [QAW-1:0] r_wptr;
    logic [QAW-1:0] r_rptr;
    logic [QAW:0]   r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == LP_FULL);
    assign w_do_pop  = i_pop && o_valid;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_clrn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + QAW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + QAW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (QAW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (QAW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Pops PS/2 scan bytes, decodes E0/F0 prefixes and modifiers, queues key events.
// Optional feature: define PS2SEQ_TYPEMATIC_EN to enqueue typematic repeats with the repeat flag set.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned QAW    = 2
) (
    input  logic       i_clk,
    input  logic       i_clrn,
    input  logic [7:0] i_ps2_data,
    input  logic       i_ps2_ready,
    output logic       o_ps2_nextdata_n,
    output logic       o_evt_valid,
    input  logic       i_evt_ready,
    output logic [7:0] o_evt_code,
    output logic       o_evt_make,
    output logic       o_evt_ext,
    output logic       o_evt_repeat,
    output logic [3:0] o_mods,
    output logic       o_evt_overflow
);

    ps2_state_t r_state;
    logic [7:0] r_byte;
    logic       r_nextdata_n;
    logic       r_ext_pend;
    logic       r_brk_pend;
    logic       r_lshift, r_rshift, r_lctrl, r_rctrl, r_alt, r_caps, r_caps_held;
    logic       r_held_valid;
    logic [8:0] r_held_key;
    logic       r_overflow;

    logic       w_make;
    logic       w_ext;
    logic       w_is_prefix;
    logic       w_is_mod;
    logic       w_key;
    logic       w_held_hit;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    ps2_evt_t   w_push_data;
    ps2_evt_t   w_head;

    always_comb begin
        w_ext       = r_ext_pend;
        w_make      = !r_brk_pend;
        w_is_prefix = (r_byte == SC_E0) || (r_byte == SC_F0);
        w_is_mod    = r_byte inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT, SC_CAPS};
        w_key       = (r_state == ACK) && !w_is_prefix && !w_is_mod;
        w_held_hit  = r_held_valid && (r_held_key == {w_ext, r_byte});
        w_push_data = '{code: r_byte, make: w_make, ext: w_ext, is_repeat: 1'b0};
`ifdef PS2SEQ_TYPEMATIC_EN
        w_push                = w_key;
        w_push_data.is_repeat = w_make && w_held_hit;
`else
        w_push                = w_key && !(w_make && w_held_hit);
`endif
    end

    assign w_pop = o_evt_valid && i_evt_ready;

    always_ff @(posedge i_clk) begin
        if (!i_clrn) begin
            r_state      <= IDLE;
            r_byte       <= '0;
            r_nextdata_n <= 1'b1;
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_lshift     <= 1'b0;
            r_rshift     <= 1'b0;
            r_lctrl      <= 1'b0;
            r_rctrl      <= 1'b0;
            r_alt        <= 1'b0;
            r_caps       <= 1'b0;
            r_caps_held  <= 1'b0;
            r_held_valid <= 1'b0;
            r_held_key   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_nextdata_n <= 1'b1;
                    if (i_ps2_ready) begin
                        r_byte       <= i_ps2_data;
                        r_nextdata_n <= 1'b0;
                        r_state      <= ACK;
                    end
                end
                ACK: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= GAP;
                    if (r_byte == SC_E0) begin
                        r_ext_pend <= 1'b1;
                    end else if (r_byte == SC_F0) begin
                        r_brk_pend <= 1'b1;
                    end else begin
                        r_ext_pend <= 1'b0;
                        r_brk_pend <= 1'b0;
                        case (r_byte)
                            SC_LSHIFT: r_lshift <= w_make;
                            SC_RSHIFT: r_rshift <= w_make;
                            SC_CTRL: begin
                                if (w_ext) r_rctrl <= w_make;
                                else       r_lctrl <= w_make;
                            end
                            SC_ALT: r_alt <= w_make;
                            SC_CAPS: begin
                                // Toggle only on the first make; auto-repeat makes are ignored.
                                if (w_make && !r_caps_held) r_caps <= !r_caps;
                                r_caps_held <= w_make;
                            end
                            default: begin
                                if (w_make && !w_held_hit) begin
                                    r_held_key   <= {w_ext, r_byte};
                                    r_held_valid <= 1'b1;
                                end else if (!w_make && w_held_hit) begin
                                    r_held_valid <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                GAP: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    ps2_evt_fifo #(
        .QDEPTH (QDEPTH),
        .QAW    (QAW)
    ) u_evt_fifo (
        .i_clk       (i_clk),
        .i_clrn      (i_clrn),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (o_evt_valid),
        .o_full      (w_full)
    );

    assign o_ps2_nextdata_n = r_nextdata_n;
    assign o_evt_code       = w_head.code;
    assign o_evt_make       = w_head.make;
    assign o_evt_ext        = w_head.ext;
    assign o_evt_repeat     = w_head.is_repeat;
    assign o_mods           = {r_caps, r_alt, r_lctrl | r_rctrl, r_lshift | r_rshift};
    assign o_evt_overflow   = r_overflow;

endmodule
